// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read sequencer: FSM encoding, bus strobe
// bundle and the fixed date/time register map.
package rtc_pkg;

  localparam int unsigned NUM_REGS = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    GAP1 = 3'd2,
    DATA = 3'd3,
    GAP2 = 3'd4,
    NEXT = 3'd5
  } state_t;

  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic a_d;
    logic ad_oe;
  } bus_t;

  // Register order: seg, min, hora, dia, mes, anio
  function automatic logic [7:0] reg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    reg_addr = 8'h21;
      3'd1:    reg_addr = 8'h22;
      3'd2:    reg_addr = 8'h23;
      3'd3:    reg_addr = 8'h24;
      3'd4:    reg_addr = 8'h25;
      3'd5:    reg_addr = 8'h26;
      default: reg_addr = 8'h21;
    endcase
  endfunction

  // Strobe levels that accompany each state; gaps and idle leave the bus released
  function automatic bus_t bus_for(input state_t st);
    bus_t b;
    b = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a_d: 1'b0, ad_oe: 1'b0};
    case (st)
      ADDR: begin
        b.cs_n  = 1'b0;
        b.wr_n  = 1'b0;
        b.ad_oe = 1'b1;
      end
      DATA: begin
        b.cs_n = 1'b0;
        b.rd_n = 1'b0;
        b.a_d  = 1'b1;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Reloadable down-counter measuring one bus phase; done is high on the
// last cycle of the phase.
module rtc_phase_timer #(
  parameter int unsigned T_PHASE = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic done
);

  localparam int unsigned CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

  logic [CW-1:0] cnt;

  // done is registered alongside the count so it lines up with cnt == 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= CW'(T_PHASE - 1);
      done <= 1'b0;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      done <= (cnt <= CW'(1));
    end
  end

endmodule

// File: rtl/rtc_read_seq.sv
// Periodic / on-demand burst reader of the six RTC date-time registers over a
// multiplexed address/data bus, publishing each byte with a one-hot strobe.
module rtc_read_seq #(
  parameter int unsigned T_PHASE = 4,
  parameter int unsigned REFRESH = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Modificando,
  input  logic [7:0] AD_in,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D,
  output logic [7:0] DATA_out,
  output logic [5:0] Actualizar,
  output logic       BUSY
);

  import rtc_pkg::*;

  localparam int unsigned RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  state_t        state;
  logic [2:0]    idx;
  logic [RW-1:0] ref_cnt;
  logic          pending;
  bus_t          bus_q;
  logic [7:0]    ad_out_q;
  logic [7:0]    data_q;
  logic [5:0]    act_q;
  logic          busy_q;
  logic          phase_done;

  logic ref_hit_c;
  logic req_c;
  logic start_c;
  logic timer_load_c;

  rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .load (timer_load_c),
    .done (phase_done)
  );

  // Burst request decode and phase-timer reload whenever a timed state is entered
  always_comb begin
    ref_hit_c    = (ref_cnt == RW'(REFRESH - 1));
    req_c        = START | pending | ref_hit_c;
    start_c      = (state == IDLE) && req_c && !Modificando;
    timer_load_c = start_c;
    case (state)
      ADDR, GAP1, DATA: if (phase_done) timer_load_c = 1'b1;
      NEXT:             if (idx != 3'(NUM_REGS - 1)) timer_load_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      ref_cnt  <= '0;
      pending  <= 1'b0;
      bus_q    <= bus_for(IDLE);
      ad_out_q <= '0;
      data_q   <= '0;
      act_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      act_q   <= '0;
      ref_cnt <= ref_hit_c ? '0 : ref_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start_c) begin
            state    <= ADDR;
            ref_cnt  <= '0;
            pending  <= 1'b0;
            busy_q   <= 1'b1;
            bus_q    <= bus_for(ADDR);
            ad_out_q <= reg_addr(idx);
          end else if (req_c) begin
            pending <= 1'b1;
          end
        end
        ADDR: if (phase_done) begin
          state <= GAP1;
          bus_q <= bus_for(GAP1);
        end
        GAP1: if (phase_done) begin
          state <= DATA;
          bus_q <= bus_for(DATA);
        end
        DATA: if (phase_done) begin
          data_q <= AD_in;
          act_q  <= 6'(6'd1 << idx);
          state  <= GAP2;
          bus_q  <= bus_for(GAP2);
        end
        GAP2: if (phase_done) begin
          state <= NEXT;
          bus_q <= bus_for(NEXT);
        end
        NEXT: begin
          if (idx == 3'(NUM_REGS - 1)) begin
            state  <= IDLE;
            idx    <= '0;
            busy_q <= 1'b0;
            bus_q  <= bus_for(IDLE);
          end else begin
            idx      <= idx + 3'd1;
            state    <= ADDR;
            bus_q    <= bus_for(ADDR);
            ad_out_q <= reg_addr(idx + 3'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign AD_out     = ad_out_q;
  assign AD_oe      = bus_q.ad_oe;
  assign CS_n       = bus_q.cs_n;
  assign RD_n       = bus_q.rd_n;
  assign WR_n       = bus_q.wr_n;
  assign A_D        = bus_q.a_d;
  assign DATA_out   = data_q;
  assign BUSY       = busy_q;
  // An edit in progress masks strobes immediately, even one already registered
  assign Actualizar = act_q & ~{6{Modificando}};

endmodule
